// File: rtl/scanner_pkg.sv
// rtl/scanner_pkg.sv - shared state encodings for the scanner controller and its display decoder.
package scanner_pkg;

  localparam int STATUS_W = 5;

  // One-hot codes consumed directly by the HEX display decoder; WAIT shows as blank.
  typedef enum logic [STATUS_W-1:0] {
    ST_IDLE     = 5'b01000,
    ST_SCAN     = 5'b10000,
    ST_TRANSFER = 5'b00100,
    ST_FLUSH    = 5'b00001,
    ST_WAIT     = 5'b00010
  } status_t;

endpackage

// File: rtl/scan_fifo.sv
// rtl/scan_fifo.sv - circular sample buffer with show-ahead head, saturating level and wrapping pointers.
module scan_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [DATA_W-1:0]            wr_data,
  output logic [DATA_W-1:0]            head,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Guard here too so level can never wrap or underflow whatever the caller does.
  assign do_push = push && (level != LVL_W'(DEPTH));
  assign do_pop  = pop && (level != '0);

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/scanner_ctrl.sv
// rtl/scanner_ctrl.sv - scanner FSM, overflow flag and transfer link around scan_fifo.
// SCANNER_AUTO_RESCAN_EN: transfer/flush completion re-enters SCAN instead of IDLE.
module scanner_ctrl
  import scanner_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int BUF_DEPTH   = 10,
  parameter int FULL_THRESH = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             stop,
  input  logic                             flush_req,
  input  logic                             sample_valid,
  input  logic [DATA_W-1:0]                sample_in,
  input  logic                             xfer_grant,
  input  logic                             xfer_ready,
  output logic                             xfer_valid,
  output logic [DATA_W-1:0]                xfer_data,
  output logic                             xfer_req,
  output logic [$clog2(BUF_DEPTH+1)-1:0]   level,
  output logic                             overflow,
  output logic [STATUS_W-1:0]              status
);

  localparam int LVL_W = $clog2(BUF_DEPTH + 1);

`ifdef SCANNER_AUTO_RESCAN_EN
  localparam status_t DONE_STATE = ST_SCAN;
`else
  localparam status_t DONE_STATE = ST_IDLE;
`endif

  status_t           state;
  logic              full;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head;

  assign full = (level == LVL_W'(BUF_DEPTH));
  assign push = (state == ST_SCAN) && sample_valid && !full;
  assign pop  = ((state == ST_TRANSFER) && xfer_valid && xfer_ready) ||
                ((state == ST_FLUSH) && (level != '0));

  scan_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (BUF_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (sample_in),
    .head    (head),
    .level   (level)
  );

  assign status     = state;
  assign xfer_valid = (state == ST_TRANSFER) && (level != '0);
  assign xfer_data  = xfer_valid ? head : '0;
  assign xfer_req   = (level >= LVL_W'(FULL_THRESH)) && ((state == ST_SCAN) || (state == ST_WAIT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (flush_req && (level != '0)) begin
            state <= ST_FLUSH;
          end else if (start) begin
            state    <= ST_SCAN;
            overflow <= 1'b0;
          end
        end
        ST_SCAN: begin
          if (sample_valid && full) overflow <= 1'b1;
          // WAIT keys off the registered level so a sample arriving at full is seen and flagged first.
          if (flush_req)                   state <= ST_FLUSH;
          else if (stop)                   state <= ST_IDLE;
          else if (xfer_grant && xfer_req) state <= ST_TRANSFER;
          else if (full)                   state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (flush_req)       state <= ST_FLUSH;
          else if (stop)       state <= ST_IDLE;
          else if (xfer_grant) state <= ST_TRANSFER;
        end
        ST_TRANSFER: begin
          if ((level == '0) || (pop && (level == LVL_W'(1)))) state <= DONE_STATE;
        end
        ST_FLUSH: begin
          if (level <= LVL_W'(1)) state <= DONE_STATE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scanner_ctrl.sv
// tb/tb_scanner_ctrl.sv - directed self-checking bench for scanner_ctrl.
module tb_scanner_ctrl;

  localparam logic [4:0] S_IDLE     = 5'b01000;
  localparam logic [4:0] S_SCAN     = 5'b10000;
  localparam logic [4:0] S_TRANSFER = 5'b00100;
  localparam logic [4:0] S_FLUSH    = 5'b00001;
  localparam logic [4:0] S_WAIT     = 5'b00010;
`ifdef SCANNER_AUTO_RESCAN_EN
  localparam logic [4:0] S_DONE     = S_SCAN;
`else
  localparam logic [4:0] S_DONE     = S_IDLE;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start, stop, flush_req, sample_valid, xfer_grant, xfer_ready;
  logic [7:0] sample_in;
  logic       xfer_valid, xfer_req, overflow;
  logic [7:0] xfer_data;
  logic [3:0] level;
  logic [4:0] status;

  int total = 0;
  int bad   = 0;

  scanner_ctrl #(.DATA_W(8), .BUF_DEPTH(10), .FULL_THRESH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .flush_req    (flush_req),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .xfer_grant   (xfer_grant),
    .xfer_ready   (xfer_ready),
    .xfer_valid   (xfer_valid),
    .xfer_data    (xfer_data),
    .xfer_req     (xfer_req),
    .level        (level),
    .overflow     (overflow),
    .status       (status)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_samples(input int n, input logic [7:0] first);
    for (int i = 0; i < n; i++) begin
      sample_valid = 1'b1;
      sample_in    = first + 8'(i);
      tick();
    end
    sample_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_data;
    int         lvl;

    reset = 1'b1;
    {start, stop, flush_req, sample_valid, xfer_grant, xfer_ready} = '0;
    sample_in = '0;
    #2;
    check("rst_status_async", 32'(status), 32'(S_IDLE));
    tick(); tick();
    check("rst_level", 32'(level), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_xfer_req", 32'(xfer_req), 0);
    check("rst_xfer_valid", 32'(xfer_valid), 0);
    check("rst_xfer_data", 32'(xfer_data), 0);
    reset = 1'b0;
    tick();

    start = 1'b1; tick(); start = 1'b0;
    check("start_scan", 32'(status), 32'(S_SCAN));
    write_samples(7, 8'h01);
    check("lvl7", 32'(level), 7);
    check("req_below_thresh", 32'(xfer_req), 0);
    write_samples(1, 8'h08);
    check("lvl8", 32'(level), 8);
    check("req_at_thresh", 32'(xfer_req), 1);
    check("scan_at_8", 32'(status), 32'(S_SCAN));

    write_samples(2, 8'h09);
    check("lvl10", 32'(level), 10);
    check("ovf_before_drop", 32'(overflow), 0);
    write_samples(1, 8'h0B);
    check("wait_state", 32'(status), 32'(S_WAIT));
    check("lvl_sat", 32'(level), 10);
    check("ovf_set", 32'(overflow), 1);

    xfer_grant = 1'b1; tick(); xfer_grant = 1'b0;
    check("grant_transfer", 32'(status), 32'(S_TRANSFER));
    check("req_in_transfer", 32'(xfer_req), 0);
    exp_data = 8'h01;
    lvl = 10;
    for (int k = 0; k < 40 && lvl != 0; k++) begin
      xfer_ready = (k % 2 == 0);
      check("xfer_valid", 32'(xfer_valid), 1);
      check("xfer_data", 32'(xfer_data), 32'(exp_data));
      check("xfer_level", 32'(level), 32'(lvl));
      tick();
      if (xfer_ready) begin
        exp_data++;
        lvl--;
      end
    end
    xfer_ready = 1'b0;
    check("xfer_done_state", 32'(status), 32'(S_DONE));
    check("xfer_done_valid", 32'(xfer_valid), 0);
    check("xfer_done_level", 32'(level), 0);
    check("ovf_sticky", 32'(overflow), 1);

    stop = 1'b1; tick(); stop = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    check("rescan", 32'(status), 32'(S_SCAN));
    check("ovf_cleared", 32'(overflow), 0);

    write_samples(5, 8'h11);
    check("pre_flush_lvl", 32'(level), 5);
    flush_req = 1'b1; tick(); flush_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("flush_state", 32'(status), 32'(S_FLUSH));
      check("flush_level", 32'(level), 32'(5 - i));
      tick();
    end
    check("flush_done_state", 32'(status), 32'(S_DONE));
    check("flush_done_level", 32'(level), 0);

    start = 1'b1; tick(); start = 1'b0;
    write_samples(8, 8'h21);
    check("prio_req", 32'(xfer_req), 1);
    stop = 1'b1; xfer_grant = 1'b1; tick();
    stop = 1'b0; xfer_grant = 1'b0;
    check("stop_beats_grant", 32'(status), 32'(S_IDLE));
    check("stop_keeps_level", 32'(level), 8);
    check("idle_no_req", 32'(xfer_req), 0);

    start = 1'b1; tick(); start = 1'b0;
    check("rescan_full8", 32'(status), 32'(S_SCAN));
    flush_req = 1'b1; stop = 1'b1; xfer_grant = 1'b1; tick();
    flush_req = 1'b0; stop = 1'b0; xfer_grant = 1'b0;
    check("flush_beats_all", 32'(status), 32'(S_FLUSH));
    for (int i = 0; i < 20 && status == S_FLUSH; i++) tick();
    check("flush8_done", 32'(status), 32'(S_DONE));
    check("flush8_level", 32'(level), 0);

    start = 1'b1; tick(); start = 1'b0;
    write_samples(8, 8'h31);
    xfer_grant = 1'b1; tick(); xfer_grant = 1'b0;
    check("mid_transfer", 32'(status), 32'(S_TRANSFER));
    xfer_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    xfer_ready = 1'b0;
    check("mid_level", 32'(level), 4);
    check("mid_data", 32'(xfer_data), 32'h35);
    #2;
    reset = 1'b1;
    #1;
    check("async_status", 32'(status), 32'(S_IDLE));
    check("async_level", 32'(level), 0);
    check("async_valid", 32'(xfer_valid), 0);
    check("async_data", 32'(xfer_data), 0);
    check("async_req", 32'(xfer_req), 0);
    check("async_ovf", 32'(overflow), 0);
    tick();
    reset = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
